// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus drain controller feeding a uart transmitter.
// Bytes are pushed at bus rate. A small FSM pops one byte at a time, presents it on tx_data,
// pulses tx_start, and then waits for the uart to report busy and then idle.
// If the uart never acknowledges within ACK_TIMEOUT cycles, the byte is treated as sent.
module uart_tx_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     ovf_clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     drain_active
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitBusy,
        StWaitDone
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic [PW-1:0] occupancy;
    logic          push;
    logic          drop;
    logic          pop;

    // Occupancy flags decoded from the registered pointers.
    always_comb begin
        occupancy = wr_ptr_q - rd_ptr_q;
    end

    assign level        = occupancy;
    assign full         = (occupancy == PW'(DEPTH));
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign overflow     = ovf_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign drain_active = (state_q != StIdle);

    // Decide this cycle's push, dropped push and pop. A flush overrides both directions,
    // and a write during a flush is discarded without counting as an overflow.
    always_comb begin
        push = wr_en & ~full & ~flush;
        drop = wr_en & full & ~flush;
        pop  = (state_q == StIdle) & ~empty & ~tx_busy & ~flush;
    end

    // Pointer and sticky-overflow next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
        // Set wins over clear.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    // Drain controller next state: launch, wait for the ack, then wait for the frame to end.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    tx_data_d  = mem_q[rd_ptr_q[AW-1:0]];
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    // No acknowledge from the uart: treat the byte as sent.
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FIFO pointers and overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Drain FSM with its registered uart-facing outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // Storage array. It needs no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomised bench for uart_tx_buffer.
// The reference model keeps the queued bytes in a queue, and it times the drain controller
// with a countdown for the acknowledge window and a flag for the frame in progress.
// A simple uart responder drives tx_busy and records the launched bytes.
module tb_uart_tx_buffer;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned ACK_TIMEOUT = 4;
    localparam int unsigned LW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          flush = 1'b0;
    logic          ovf_clear = 1'b0;
    logic          tx_busy = 1'b0;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          drain_active;

    uart_tx_buffer #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .ovf_clear    (ovf_clear),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .drain_active (drain_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q [$];
    bit         m_ovf;
    int         m_ack_left;
    bit         m_in_frame;
    logic [7:0] m_data;
    bit         m_start;

    // uart responder state: 0 normal ack, 1 never acks, 2 slow/late ack
    int         mode = 0;
    bit         force_busy = 1'b0;
    bit         u_pend = 1'b0;
    int         u_dly = 0;
    int         u_len = 0;
    int         u_busy_left = 0;
    int         u_len_min = 1;
    int         u_len_max = 5;
    logic [7:0] rx [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 1'b0;
        m_ack_left = 0;
        m_in_frame = 1'b0;
        m_data     = 8'h00;
        m_start    = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("level", 32'(level), m_q.size());
        check_eq("full", 32'(full), 32'(m_q.size() == DEPTH));
        check_eq("empty", 32'(empty), 32'(m_q.size() == 0));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("tx_start", 32'(tx_start), 32'(m_start));
        check_eq("tx_data", 32'(tx_data), 32'(m_data));
        check_eq("drain_active", 32'(drain_active), 32'(m_ack_left > 0 || m_in_frame));
    endtask

    // The uart sees the launch pulse and raises busy for a random frame length.
    task automatic uart_step();
        if (tx_start === 1'b1) begin
            rx.push_back(tx_data);
            if (mode != 1) begin
                u_pend = 1'b1;
                u_dly  = (mode == 2) ? int'($urandom_range(0, 6)) : 0;
                u_len  = int'($urandom_range(u_len_min, u_len_max));
            end
        end
        if (u_pend) begin
            if (u_dly == 0) begin
                u_pend      = 1'b0;
                u_busy_left = u_len;
            end else begin
                u_dly--;
            end
        end
        tx_busy = force_busy || (u_busy_left > 0);
        if (u_busy_left > 0) u_busy_left--;
    endtask

    // Advance the model across one rising edge using the inputs now being applied.
    task automatic model_update();
        bit full_now;
        bit empty_now;
        if (!reset) begin
            model_reset();
            return;
        end
        full_now  = (m_q.size() == DEPTH);
        empty_now = (m_q.size() == 0);
        m_start   = 1'b0;
        if (m_ack_left == 0 && !m_in_frame) begin
            if (!empty_now && !tx_busy && !flush) begin
                m_data     = m_q.pop_front();
                m_start    = 1'b1;
                m_ack_left = ACK_TIMEOUT;
            end
        end else if (m_ack_left > 0) begin
            if (tx_busy) begin
                m_ack_left = 0;
                m_in_frame = 1'b1;
            end else begin
                m_ack_left--;
            end
        end else if (!tx_busy) begin
            m_in_frame = 1'b0;
        end
        if (flush) m_q.delete();
        else if (wr_en && !full_now) m_q.push_back(wr_data);
        if (wr_en && full_now && !flush) m_ovf = 1'b1;
        else if (ovf_clear) m_ovf = 1'b0;
    endtask

    // One cycle: check outputs at the falling edge, apply the inputs, and advance the model.
    task automatic step(input logic we, input logic [7:0] wd, input logic fl, input logic oc);
        check_outputs();
        uart_step();
        wr_en     = we;
        wr_data   = wd;
        flush     = fl;
        ovf_clear = oc;
        model_update();
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (m_q.size() == 0 && m_ack_left == 0 && !m_in_frame && !u_pend &&
                u_busy_left == 0) break;
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check_eq("drain_idle", 32'(drain_active), 0);
        check_eq("drain_empty", 32'(empty), 1);
    endtask

    initial begin
        int cnt;
        int pushed;
        logic [7:0] burst [3];
        burst[0] = 8'hA1;
        burst[1] = 8'hB2;
        burst[2] = 8'hC3;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Single byte: launch two cycles after the push, and the pulse lasts exactly one cycle
        rx.delete();
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check_eq("single_no_early_start", 32'(tx_start), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("single_latency_start", 32'(tx_start), 1);
        check_eq("single_data", 32'(tx_data), 32'h55);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("single_pulse_width", 32'(tx_start), 0);
        drain(50);
        check_eq("single_rx_count", rx.size(), 1);
        if (rx.size() > 0) check_eq("single_rx_byte", 32'(rx[0]), 32'h55);

        // Burst order
        rx.delete();
        for (int i = 0; i < 3; i++) step(1'b1, burst[i], 1'b0, 1'b0);
        drain(100);
        check_eq("burst_rx_count", rx.size(), 3);
        for (int i = 0; i < rx.size() && i < 3; i++) check_eq("burst_order", 32'(rx[i]), 32'(burst[i]));

        // Overflow with the uart held busy
        rx.delete();
        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        check_eq("ovf_full", 32'(full), 1);
        check_eq("ovf_level", 32'(level), DEPTH);
        check_eq("ovf_flag", 32'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(overflow), 0);
        force_busy = 1'b0;
        drain(300);
        check_eq("ovf_rx_count", rx.size(), DEPTH);
        for (int i = 0; i < rx.size() && i < DEPTH; i++) check_eq("ovf_rx_order", 32'(rx[i]), 32'h80 + i);

        // Wrap: 40 bytes through the FIFO
        rx.delete();
        pushed = 0;
        for (int c = 0; c < 2000 && pushed < 40; c++) begin
            if (m_q.size() < DEPTH && ($urandom_range(0, 3) != 0)) begin
                step(1'b1, 8'(pushed), 1'b0, 1'b0);
                pushed++;
            end else begin
                step(1'b0, 8'h00, 1'b0, 1'b0);
            end
        end
        drain(500);
        check_eq("wrap_rx_count", rx.size(), 40);
        for (int i = 0; i < rx.size() && i < 40; i++) check_eq("wrap_order", 32'(rx[i]), i);
        check_eq("wrap_level", 32'(level), 0);

        // Timeout: the uart never acknowledges
        mode = 1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (drain_active === 1'b1) cnt++;
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check_eq("timeout_len", cnt, ACK_TIMEOUT);
        mode = 0;

        // Flush with a simultaneous write
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        check_eq("flush_level", 32'(level), 0);
        check_eq("flush_no_ovf", 32'(overflow), 0);
        force_busy = 1'b0;
        rx.delete();
        drain(50);
        check_eq("flush_rx_none", rx.size(), 0);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                mode       = int'($urandom_range(0, 2));
                force_busy = ($urandom_range(0, 9) == 0);
            end
            step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 80) == 0),
                 1'($urandom_range(0, 20) == 0));
        end
        force_busy = 1'b0;
        mode = 0;
        drain(500);

        // Reset in the middle of a drain
        u_len_min = 8;
        u_len_max = 12;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        for (int c = 0; c < 30 && !m_in_frame; c++) step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("rst_mid_in_frame", 32'(drain_active), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_tx_start", 32'(tx_start), 0);
        check_eq("rst_drain_active", 32'(drain_active), 0);
        check_eq("rst_empty", 32'(empty), 1);
        check_eq("rst_full", 32'(full), 0);
        check_eq("rst_tx_data", 32'(tx_data), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        model_reset();
        @(negedge clk);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        u_len_min = 1;
        u_len_max = 5;
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
